// File: rtl/decode_stage.sv
// Decode stage: splits the IF_ID word into MIPS-like fields, reads the 32x32 register file,
// sign-extends the immediate, resolves the destination register, detects load-use hazards and
// registers the packed result into ID_EX behind a valid/ready handshake.
//
// Build option: define DECODE_WB_BYPASS_EN to forward same-cycle write-back data into the
// captured rs_val/rt_val (write-through). Without it the pre-write register value is captured.
module decode_stage #(
   parameter int unsigned NREGS    = 32,
   parameter logic [5:0]  LOAD_OP  = 6'h23,
   parameter logic [5:0]  STORE_OP = 6'h2B
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [63:0]   IF_ID,
   input  logic          if_valid,
   output logic          id_ready,
   input  logic          flush,
   input  logic          ex_ready,
   output logic          id_valid,
   output logic [149:0]  ID_EX,
   input  logic          wb_en,
   input  logic [4:0]    wb_addr,
   input  logic [31:0]   wb_data
);

   // Branch opcodes that write no register
   localparam logic [5:0] BeqOp = 6'h04;
   localparam logic [5:0] BneOp = 6'h05;

   // Instruction fields
   logic [31:0] pc;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [4:0]  dst;

   // Register file and operand values
   logic [31:0] rf_q [NREGS];
   logic [31:0] rs_rf;
   logic [31:0] rt_rf;
   logic [31:0] rs_val;
   logic [31:0] rt_val;

   // Pipeline register and control
   logic [149:0] id_ex_q;
   logic [149:0] id_ex_d;
   logic         id_valid_q;
   logic         id_valid_d;
   logic [149:0] decoded;
   logic [5:0]   ex_opcode;
   logic [4:0]   ex_dst;
   logic         hazard;
   logic         advance;

   assign pc    = IF_ID[63:32];
   assign instr = IF_ID[31:0];

   // Field extraction and immediate sign extension
   always_comb begin
      opcode   = instr[31:26];
      rs       = instr[25:21];
      rt       = instr[20:16];
      rd       = instr[15:11];
      shamt    = instr[10:6];
      funct    = instr[5:0];
      imm      = instr[15:0];
      imm_sext = {{16{imm[15]}}, imm};
   end

   // Destination register: R-type writes rd, stores/branches write nothing, others write rt
   always_comb begin
      dst = rt;
      if (opcode == 6'h00) begin
         dst = rd;
      end else if (opcode == STORE_OP || opcode == BeqOp || opcode == BneOp) begin
         dst = 5'd0;
      end
   end

   // Register-file read ports; register 0 always reads as zero
   always_comb begin
      rs_rf = (rs == 5'd0) ? 32'd0 : rf_q[rs];
      rt_rf = (rt == 5'd0) ? 32'd0 : rf_q[rt];
   end

`ifdef DECODE_WB_BYPASS_EN
   // Write-through: a same-cycle write-back to a source register is seen by this decode
   always_comb begin
      rs_val = rs_rf;
      rt_val = rt_rf;
      if (wb_en && wb_addr != 5'd0 && wb_addr == rs) begin
         rs_val = wb_data;
      end
      if (wb_en && wb_addr != 5'd0 && wb_addr == rt) begin
         rt_val = wb_data;
      end
   end
`else
   // No forwarding: the value stored before this cycle's write-back is captured
   always_comb begin
      rs_val = rs_rf;
      rt_val = rt_rf;
   end
`endif

   // Register-file write port; writes to register 0 are dropped
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            rf_q[i] <= 32'd0;
         end
      end else if (wb_en && wb_addr != 5'd0) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // Packed ID_EX word for the instruction currently in IF_ID
   always_comb begin
      decoded = {pc, rs_val, rt_val, imm_sext, dst, opcode, funct, shamt};
   end

   // Load-use hazard against the load sitting in ID_EX, plus handshake terms
   always_comb begin
      ex_opcode = id_ex_q[16:11];
      ex_dst    = id_ex_q[21:17];
      hazard    = id_valid_q && (ex_opcode == LOAD_OP) && (ex_dst != 5'd0) &&
                  ((ex_dst == rs) || (ex_dst == rt));
      advance   = !id_valid_q || ex_ready;
      id_ready  = advance && !hazard;
   end

   // Next-state for ID_EX: flush, bubble, accept, drain, else hold
   always_comb begin
      id_valid_d = id_valid_q;
      id_ex_d    = id_ex_q;
      if (flush) begin
         id_valid_d = 1'b0;
      end else if (advance) begin
         if (hazard) begin
            // Bubble; ID_EX contents are stale but invalid
            id_valid_d = 1'b0;
         end else if (if_valid) begin
            id_ex_d    = decoded;
            id_valid_d = 1'b1;
         end else begin
            id_valid_d = 1'b0;
         end
      end
   end

   // ID_EX pipeline register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_ex_q    <= '0;
         id_valid_q <= 1'b0;
      end else begin
         id_ex_q    <= id_ex_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign ID_EX    = id_ex_q;
   assign id_valid = id_valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a behavioural model of the stage.
module tb_decode_stage;

   logic          clock = 1'b0;
   logic          reset;
   logic [63:0]   IF_ID;
   logic          if_valid;
   logic          id_ready;
   logic          flush;
   logic          ex_ready;
   logic          id_valid;
   logic [149:0]  ID_EX;
   logic          wb_en;
   logic [4:0]    wb_addr;
   logic [31:0]   wb_data;

   decode_stage dut (
      .clock    (clock),
      .reset    (reset),
      .IF_ID    (IF_ID),
      .if_valid (if_valid),
      .id_ready (id_ready),
      .flush    (flush),
      .ex_ready (ex_ready),
      .id_valid (id_valid),
      .ID_EX    (ID_EX),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   // Reference state
   logic [31:0]  regs [32];
   logic         m_vld;
   logic [149:0] m_word;
   logic [149:0] sb_q [$];

   task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (we && wa == a) return wd;
`endif
      return regs[a];
   endfunction

   // Architectural meaning of one instruction as seen by execute
   function automatic logic [149:0] model_decode(input logic [63:0] w, input logic we,
                                                 input logic [4:0] wa, input logic [31:0] wd);
      logic [31:0] ins;
      logic [5:0]  op;
      logic [4:0]  d;
      ins = w[31:0];
      op  = ins[31:26];
      if (op == 6'h00) d = ins[15:11];
      else if (op == 6'h2B || op == 6'h04 || op == 6'h05) d = 5'd0;
      else d = ins[20:16];
      return {w[63:32], rd_reg(ins[25:21], we, wa, wd), rd_reg(ins[20:16], we, wa, wd),
              {{16{ins[15]}}, ins[15:0]}, d, op, ins[5:0], ins[10:6]};
   endfunction

   function automatic logic m_hazard(input logic [63:0] w);
      logic [4:0] d;
      d = m_word[21:17];
      return m_vld && m_word[16:11] == 6'h23 && d != 5'd0 &&
             (d == w[25:21] || d == w[20:16]);
   endfunction

   // One clock of stimulus; called right after a falling edge, returns at the next one
   task automatic drive(input logic iv, input logic [63:0] w, input logic er, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      logic hz;
      logic adv;
      if_valid = iv; IF_ID = w; ex_ready = er; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      hz  = m_hazard(w);
      adv = !m_vld || er;
      chk("id_ready", {149'd0, id_ready}, {149'd0, adv && !hz});
      @(posedge clock);
      if (fl) begin
         m_vld = 1'b0;
         sb_q.delete();
      end else if (adv) begin
         if (hz) begin
            m_vld = 1'b0;
         end else if (iv) begin
            m_word = model_decode(w, we, wa, wd);
            m_vld  = 1'b1;
            sb_q.push_back(m_word);
         end else begin
            m_vld = 1'b0;
         end
      end
      if (we && wa != 5'd0) regs[wa] = wd;
      @(negedge clock);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      m_vld  = 1'b0;
      m_word = '0;
      sb_q.delete();
   endtask

   // Monitor: just before each rising edge, a handshake pops and compares the scoreboard
   initial begin
      logic [149:0] exp;
      forever begin
         @(negedge clock);
         #4;
         if (mon_en && reset) begin
            chk("id_valid", {149'd0, id_valid}, {149'd0, sb_q.size() != 0});
            if (id_valid && ex_ready && !flush && sb_q.size() != 0) begin
               exp = sb_q.pop_front();
               chk("ID_EX", ID_EX, exp);
            end
         end
      end
   end

   initial begin
      logic [149:0] snap;
      logic [31:0]  r;
      logic [5:0]   op;
      logic [4:0]   rs;
      logic [4:0]   rt;
      logic [4:0]   rd;
      logic [10:0]  lo;
      logic [63:0]  w;

      reset = 1'b0; IF_ID = '0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      model_reset();
      #1;
      chk("rst_id_valid", {149'd0, id_valid}, 150'd0);
      chk("rst_ID_EX", ID_EX, 150'd0);
      chk("rst_id_ready", {149'd0, id_ready}, 150'd1);
      @(posedge clock);
      @(negedge clock);
      reset  = 1'b1;
      mon_en = 1'b1;

      // Reset/accept
      drive(1'b1, 64'h00000000_0AAAAAAA, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("acc_valid", {149'd0, id_valid}, 150'd1);
      chk("acc_pc", {118'd0, ID_EX[149:118]}, 150'd0);
      chk("acc_op", {144'd0, ID_EX[16:11]}, 150'h2);
      chk("acc_imm", {118'd0, ID_EX[53:22]}, {118'd0, 32'hFFFFAAAA});

      // Write then read
      drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
      drive(1'b1, {32'h100, 32'h00A63820}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("wr_rs_val", {118'd0, ID_EX[117:86]}, {118'd0, 32'hDEADBEEF});
      chk("wr_dst", {145'd0, ID_EX[21:17]}, 150'd7);

      // Register 0 ignores writes
      drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
      drive(1'b1, {32'h104, 32'h00003820}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("r0_zero", {118'd0, ID_EX[117:86]}, 150'd0);

      // Load-use: lw r5 then a reader of r5
      drive(1'b1, {32'h108, 32'h8C050000}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      IF_ID = {32'h10C, 32'h00A63820};
      #1;
      chk("lu_ready", {149'd0, id_ready}, 150'd0);
      drive(1'b1, {32'h10C, 32'h00A63820}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lu_bubble", {149'd0, id_valid}, 150'd0);
      drive(1'b1, {32'h10C, 32'h00A63820}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lu_accept", {149'd0, id_valid}, 150'd1);
      chk("lu_pc", {118'd0, ID_EX[149:118]}, 150'h10C);

      // Back-pressure for three cycles
      snap = ID_EX;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, {32'h110, 32'h00003820}, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
         chk("bp_hold", ID_EX, snap);
         chk("bp_ready", {149'd0, id_ready}, 150'd0);
      end
      drive(1'b1, {32'h110, 32'h00003820}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("bp_release", {118'd0, ID_EX[149:118]}, 150'h110);

      // Flush beats a valid fetch
      drive(1'b1, {32'h114, 32'h00003820}, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      chk("flush", {149'd0, id_valid}, 150'd0);

      // Same-cycle write-back of rt
      drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h11111111);
      drive(1'b1, {32'h118, 32'h00A63820}, 1'b1, 1'b0, 1'b1, 5'd6, 32'h12345678);
`ifdef DECODE_WB_BYPASS_EN
      chk("bypass_rt", {118'd0, ID_EX[85:54]}, {118'd0, 32'h12345678});
`else
      chk("bypass_rt", {118'd0, ID_EX[85:54]}, {118'd0, 32'h11111111});
`endif

      // Asynchronous reset mid-stream
      drive(1'b1, {32'h11C, 32'h00A63820}, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", {149'd0, id_valid}, 150'd0);
      chk("arst_ID_EX", ID_EX, 150'd0);
      chk("arst_ready", {149'd0, id_ready}, 150'd1);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      // Randomized traffic over a small register window to provoke hazards and forwarding
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 6))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h05;
            5: op = 6'h08;
            default: begin r = $urandom(); op = r[5:0]; end
         endcase
         rs = 5'($urandom_range(0, 3));
         rt = 5'($urandom_range(0, 3));
         r  = $urandom();
         rd = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : r[15:11];
         lo = r[10:0];
         w  = {r ^ 32'h5A5A0000, op, rs, rt, rd, lo};
         r  = $urandom();
         drive($urandom_range(0, 9) < 8, w, $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 1) != 0,
               5'($urandom_range(0, 3)), r);
      end
      drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage; consumes the 64-bit IF_ID word from fetch: {pc[63:32], instruction[31:0]}.
- Holds a 32x32 register file and splits the instruction into fields using a MIPS-like format.
- Sign-extends the immediate, resolves the destination register and detects load-use hazards.
- Registers the result into a packed ID_EX word with a valid/ready handshake towards execute.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hard-wired to zero.
- LOAD_OP, 6'h23, opcode treated as a load for hazard detection.
- STORE_OP, 6'h2B, opcode that writes no register.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- IF_ID  in  64  [63:32] pc, [31:0] instruction.
- if_valid  in  1  IF_ID holds a valid instruction this cycle.
- id_ready  out  1  decode accepts IF_ID this cycle; combinational.
- flush  in  1  squash the instruction in decode and the ID_EX contents.
- ex_ready  in  1  execute consumes ID_EX this cycle.
- id_valid  out  1  ID_EX holds a valid instruction.
- ID_EX  out  150  [149:118] pc, [117:86] rs_val, [85:54] rt_val, [53:22] imm_sext, [21:17] dst, [16:11] opcode, [10:5] funct, [4:0] shamt.
- wb_en  in  1  write-back strobe.
- wb_addr  in  5  write-back register index.
- wb_data  in  32  write-back data.

Behaviour:
- Field mapping: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], funct = [5:0], imm = [15:0].
- imm_sext = {{16{imm[15]}}, imm}.
- dst: opcode 0 -> rd; STORE_OP, 6'h04 or 6'h05 -> 0 (no write); all other opcodes -> rt.
- Register file: read combinationally from rs and rt; a read of register 0 returns 0.
- Register-file write: on the clock edge when wb_en=1 and wb_addr!=0. A write to register 0 is ignored.
- Load-use hazard: hazard = id_valid && ID_EX[16:11]==LOAD_OP && ID_EX[21:17]!=0 && (ID_EX[21:17]==rs || ID_EX[21:17]==rt).
- advance = !id_valid || ex_ready.
- id_ready = advance && !hazard.
- Each rising edge (priority order):
  1. flush=1: id_valid<=0; IF_ID is not accepted even if if_valid=1.
  2. advance && hazard: bubble; id_valid<=0 and ID_EX holds its old contents (don't-care while invalid); instruction stays in IF_ID.
  3. advance && if_valid: ID_EX<=decoded word, id_valid<=1.
  4. advance && !if_valid: id_valid<=0.
  5. otherwise (stall, id_valid=1 and ex_ready=0): ID_EX and id_valid hold.
- Latency: one cycle from IF_ID acceptance to id_valid.
- Throughput: one instruction per cycle when there is no hazard and ex_ready=1.
- Reset (reset=0, asynchronous): id_valid=0, ID_EX=0, all registers=0. id_ready is 1 during reset.
- Reset mid-operation discards the in-flight instruction; there is no recovery.
- Same-cycle write-back and read of the same register: see Optional Feature.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: when wb_en=1, wb_addr!=0 and wb_addr equals rs (or rt), the corresponding rs_val/rt_val captured into ID_EX is wb_data (write-through).
- Undefined: the register-file value from before the write is captured; software must space dependent instructions.

Test Plan:
- Reset/accept: release reset, IF_ID=64'h00000000_0AAAAAAA, if_valid=1, ex_ready=1 -> next cycle id_valid=1, ID_EX pc=0, opcode=6'h02, imm_sext=32'hFFFFAAAA.
- Write/read:
  - wb_en=1, wb_addr=5, wb_data=32'hDEADBEEF; next cycle decode R-type 32'h00A63820 (rs=5, rt=6, rd=7) -> rs_val=32'hDEADBEEF, dst=7.
  - Write to register 0 -> a read of register 0 still returns 0.
- Load-use: ID_EX holds lw (opcode 6'h23, dst=5); IF_ID reads rs=5 -> id_ready=0 for one cycle, a bubble is inserted (id_valid=0), then the instruction is accepted on the next cycle.
- Back-pressure: id_valid=1, ex_ready=0 for 3 cycles -> ID_EX stable, id_ready=0; ex_ready=1 -> the next instruction is accepted.
- Flush and reset:
  - flush=1 together with if_valid=1 -> id_valid=0 next cycle.
  - Assert reset asynchronously mid-stream -> id_valid and ID_EX clear immediately without a clock edge.
- Bypass: same-cycle wb_addr=6, wb_data=32'h12345678 with decode reading rt=6 -> rt_val=32'h12345678 with DECODE_WB_BYPASS_EN, the previous value of register 6 without it.
